// File: rtl/frame_cfg_pkg.sv
// Shared configuration for the column frame strobe controller.
// Holds the FSM state type, the default timing constants and a small helper.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } frame_state_e;

    localparam int DEF_MAX_FRAMES     = 20;
    localparam int DEF_FRAME_BITS     = 32;
    localparam int DEF_COL_W          = 5;
    localparam int DEF_SETUP_CYCLES   = 1;
    localparam int DEF_STROBE_CYCLES  = 2;
    localparam int DEF_HOLD_CYCLES    = 1;
    localparam int FRAME_IDX_W        = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/frame_onehot_dec.sv
// Combinational frame-index to one-hot strobe decode.
// Indices at or beyond N produce an all-zero vector.
module frame_onehot_dec
    import frame_cfg_pkg::*;
#(
    parameter int N     = DEF_MAX_FRAMES,
    parameter int IDX_W = FRAME_IDX_W
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [N-1:0]     onehot_o
);

    // One bit per frame slot, set only where the slot matches the index.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = (idx_i == IDX_W'(i));
        end
    end

endmodule

// File: rtl/column_frame_strobe_ctrl.sv
// Per-column configuration frame writer: latches frame data, then issues a
// timed one-hot strobe (setup / strobe / hold) into the column bottom tile.
module column_frame_strobe_ctrl
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = DEF_MAX_FRAMES,
    parameter int FrameBitsPerRow = DEF_FRAME_BITS,
    parameter int ColumnID        = 0,
    parameter int COL_W           = DEF_COL_W,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES   = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [COL_W-1:0]           req_col,
    input  logic [4:0]                 req_frame,
    input  logic [FrameBitsPerRow-1:0] req_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err_frame_range,
    input  logic                       err_clr,
    output logic [15:0]                frames_written
);

    localparam int MAX_CYC = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam bit HAS_SETUP = (SETUP_CYCLES > 0);
    localparam bit HAS_HOLD  = (HOLD_CYCLES > 0);

    // Counter holds "cycles remaining minus one" for the current phase.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(HAS_SETUP ? SETUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HAS_HOLD ? HOLD_CYCLES - 1 : 0);
    localparam logic [31:0]      MAX_FRAMES_U = 32'(MaxFramesPerCol);

    frame_state_e               state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [4:0]                 frame_idx_q, frame_idx_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic [15:0]                frames_written_q, frames_written_d;
    logic                       err_q, err_d;

    logic                       accept_s;
    logic                       col_match_s;
    logic                       range_bad_s;
    logic                       range_err_s;
    logic [MaxFramesPerCol-1:0] onehot_s;

    assign accept_s    = req_valid && (state_q == IDLE);
    assign col_match_s = (req_col == COL_W'(ColumnID));
    assign range_bad_s = ({27'd0, req_frame} >= MAX_FRAMES_U);
    assign range_err_s = accept_s && col_match_s && range_bad_s;

    // Decode the index that will be live next cycle so the strobe can be registered.
    frame_onehot_dec #(
        .N     (MaxFramesPerCol),
        .IDX_W (5)
    ) u_dec (
        .idx_i    (frame_idx_d),
        .onehot_o (onehot_s)
    );

    // Next-state, phase timer, data latch, strobe, counter and error flag.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        frame_idx_d      = frame_idx_q;
        frame_data_d     = frame_data_q;
        frames_written_d = frames_written_q;
        err_d            = range_err_s | (err_q & ~err_clr);

        case (state_q)
            IDLE: begin
                if (accept_s && col_match_s && !range_bad_s) begin
                    frame_data_d = req_data;
                    frame_idx_d  = req_frame;
                    if (HAS_SETUP) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LOAD;
                    end else begin
                        state_d = STROBE;
                        cnt_d   = STROBE_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    frames_written_d = frames_written_q + 16'd1;
                    if (HAS_HOLD) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_d == STROBE) begin
            strobe_d = onehot_s;
        end else begin
            strobe_d = '0;
        end
    end

    // State and output registers; reset drops any strobe in flight immediately.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            frame_idx_q      <= 5'd0;
            frame_data_q     <= '0;
            strobe_q         <= '0;
            frames_written_q <= 16'd0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            frame_idx_q      <= frame_idx_d;
            frame_data_q     <= frame_data_d;
            strobe_q         <= strobe_d;
            frames_written_q <= frames_written_d;
            err_q            <= err_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign FrameData       = frame_data_q;
    assign FrameStrobe     = strobe_q;
    assign err_frame_range = err_q;
    assign frames_written  = frames_written_q;

endmodule

// File: tb/tb_column_frame_strobe_ctrl.sv
// Self-checking bench: instance A uses default timing, instance B has no setup/hold.
// Expected behaviour comes from a transaction-level model of the phase timeline.
module tb_column_frame_strobe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid_a, valid_b, clr_a, clr_b;
    logic [4:0]  req_col;
    logic [4:0]  req_frame;
    logic [31:0] req_data;
    logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;
    logic [31:0] fd_a, fd_b;
    logic [19:0] fs_a, fs_b;
    logic [15:0] fw_a, fw_b;

    int n_cmp;
    int n_fail;

    // Model state per instance: index 0 = A, 1 = B
    logic [31:0] exp_fd [2];
    logic [15:0] exp_fw [2];
    logic        exp_err[2];
    int          ph_s   [2];
    int          ph_t   [2];
    int          ph_h   [2];

    column_frame_strobe_ctrl u_dut_a (
        .CLK(clk), .resetn(rst_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_col(req_col), .req_frame(req_frame), .req_data(req_data),
        .FrameData(fd_a), .FrameStrobe(fs_a), .busy(busy_a),
        .err_frame_range(err_a), .err_clr(clr_a), .frames_written(fw_a)
    );

    column_frame_strobe_ctrl #(.SETUP_CYCLES(0), .HOLD_CYCLES(0)) u_dut_b (
        .CLK(clk), .resetn(rst_n), .req_valid(valid_b), .req_ready(ready_b),
        .req_col(req_col), .req_frame(req_frame), .req_data(req_data),
        .FrameData(fd_b), .FrameStrobe(fs_b), .busy(busy_b),
        .err_frame_range(err_b), .err_clr(clr_b), .frames_written(fw_b)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] o_fs(input bit w);    return w ? fs_b : fs_a;       endfunction
    function automatic logic [31:0] o_fd(input bit w);    return w ? fd_b : fd_a;       endfunction
    function automatic logic        o_busy(input bit w);  return w ? busy_b : busy_a;   endfunction
    function automatic logic        o_ready(input bit w); return w ? ready_b : ready_a; endfunction
    function automatic logic        o_err(input bit w);   return w ? err_b : err_a;     endfunction
    function automatic logic [15:0] o_fw(input bit w);    return w ? fw_b : fw_a;       endfunction

    // Strobe expected k cycles after the acceptance cycle for a valid frame.
    function automatic logic [19:0] m_strobe(input int k, input int frame, input int s, input int t);
        logic [19:0] one;
        one = 20'd1;
        if (k > s && k <= s + t) return one << frame;
        return 20'd0;
    endfunction

    function automatic logic m_busy(input int k, input int s, input int t, input int h);
        return (k >= 1) && (k <= s + t + h);
    endfunction

    // Present one request in the cycle after the block is ready; returns at sample point k=1.
    task automatic send(input bit w, input logic [4:0] col, input logic [4:0] frame,
                        input logic [31:0] data, input bit clr);
        int waited;
        waited = 0;
        while (o_ready(w) !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (o_ready(w) !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout inst=%0d got=%b exp=1", w, o_ready(w));
        end
        req_col   = col;
        req_frame = frame;
        req_data  = data;
        if (w) begin valid_b = 1'b1; clr_b = clr; end
        else   begin valid_a = 1'b1; clr_a = clr; end
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        req_col   = 5'($urandom);
        req_frame = 5'($urandom);
        req_data  = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (o_fs(w) !== 20'd0 || o_fd(w) !== 32'd0 || o_fw(w) !== 16'd0 ||
                o_err(w) !== 1'b0 || o_busy(w) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs inst=%0d got fs=%h fd=%h fw=%0d err=%b busy=%b exp all 0",
                         w, o_fs(w), o_fd(w), o_fw(w), o_err(w), o_busy(w));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (o_ready(w) !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready inst=%0d got=%b exp=1", w, o_ready(w));
            end
        end
    endtask

    task automatic test_basic();
        send(1'b0, 5'd0, 5'd7, 32'hA5A5A5A5, 1'b0);
        exp_fd[0] = 32'hA5A5A5A5;
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (fd_a !== exp_fd[0] || fs_a !== m_strobe(k, 7, 1, 2) ||
                busy_a !== m_busy(k, 1, 2, 1) || ready_a !== !m_busy(k, 1, 2, 1)) begin
                n_fail++;
                $display("FAIL basic k=%0d got fd=%h fs=%h busy=%b ready=%b exp fd=%h fs=%h busy=%b",
                         k, fd_a, fs_a, busy_a, ready_a, exp_fd[0], m_strobe(k, 7, 1, 2), m_busy(k, 1, 2, 1));
            end
            if (k < 5) @(negedge clk);
        end
        exp_fw[0] = exp_fw[0] + 16'd1;
        n_cmp++;
        if (fw_a !== exp_fw[0]) begin
            n_fail++;
            $display("FAIL basic_count got=%0d exp=%0d", fw_a, exp_fw[0]);
        end
    endtask

    task automatic test_col_mismatch();
        send(1'b0, 5'd3, 5'd5, 32'h12345678, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (fs_a !== 20'd0 || busy_a !== 1'b0 || ready_a !== 1'b1 || fd_a !== exp_fd[0]) begin
                n_fail++;
                $display("FAIL col_mismatch k=%0d got fs=%h busy=%b ready=%b fd=%h exp fs=0 busy=0 ready=1 fd=%h",
                         k, fs_a, busy_a, ready_a, fd_a, exp_fd[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_range_err();
        send(1'b0, 5'd0, 5'd20, 32'hDEADBEEF, 1'b0);
        n_cmp++;
        if (err_a !== 1'b1 || fs_a !== 20'd0 || busy_a !== 1'b0 || fd_a !== exp_fd[0]) begin
            n_fail++;
            $display("FAIL range_set got err=%b fs=%h busy=%b fd=%h exp err=1 fs=0 busy=0 fd=%h",
                     err_a, fs_a, busy_a, fd_a, exp_fd[0]);
        end
        send(1'b0, 5'd0, 5'd25, 32'h0BADF00D, 1'b1);
        n_cmp++;
        if (err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL range_set_wins got=%b exp=1", err_a);
        end
        clr_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_a = 1'b0;
        exp_err[0] = 1'b0;
        n_cmp++;
        if (err_a !== 1'b0 || fw_a !== exp_fw[0]) begin
            n_fail++;
            $display("FAIL range_clear got err=%b fw=%0d exp err=0 fw=%0d", err_a, fw_a, exp_fw[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  frames [2];
        logic [31:0] datas  [2];
        frames[0] = 5'd0;  datas[0] = $urandom;
        frames[1] = 5'd19; datas[1] = $urandom;
        for (int r = 0; r < 2; r++) begin
            send(1'b1, 5'd0, frames[r], datas[r], 1'b0);
            exp_fd[1] = datas[r];
            for (int k = 1; k <= 3; k++) begin
                n_cmp++;
                if (fs_b !== m_strobe(k, frames[r], 0, 2) || busy_b !== m_busy(k, 0, 2, 0) ||
                    fd_b !== exp_fd[1]) begin
                    n_fail++;
                    $display("FAIL b2b r=%0d k=%0d got fs=%h busy=%b fd=%h exp fs=%h busy=%b fd=%h",
                             r, k, fs_b, busy_b, fd_b, m_strobe(k, frames[r], 0, 2),
                             m_busy(k, 0, 2, 0), exp_fd[1]);
                end
                if (k < 3) @(negedge clk);
            end
            exp_fw[1] = exp_fw[1] + 16'd1;
        end
        n_cmp++;
        if (fw_b !== exp_fw[1]) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=%0d", fw_b, exp_fw[1]);
        end
    endtask

    task automatic test_reset_mid_strobe();
        send(1'b0, 5'd0, 5'd4, 32'hCAFE0004, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (fs_a !== 20'h00010) begin
            n_fail++;
            $display("FAIL mid_pre_strobe got=%h exp=00010", fs_a);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (fs_a !== 20'd0 || fw_a !== 16'd0 || busy_a !== 1'b0 || fd_a !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset got fs=%h fw=%0d busy=%b fd=%h exp all 0", fs_a, fw_a, busy_a, fd_a);
        end
        for (int w = 0; w < 2; w++) begin
            exp_fd[w] = 32'd0; exp_fw[w] = 16'd0; exp_err[w] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 5'd0, 5'd4, 32'h44440004, 1'b0);
        exp_fd[0] = 32'h44440004;
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (fs_a !== m_strobe(k, 4, 1, 2) || ready_a !== !m_busy(k, 1, 2, 1)) begin
                n_fail++;
                $display("FAIL mid_after k=%0d got fs=%h ready=%b exp fs=%h", k, fs_a, ready_a, m_strobe(k, 4, 1, 2));
            end
            if (k < 5) @(negedge clk);
        end
        exp_fw[0] = exp_fw[0] + 16'd1;
        n_cmp++;
        if (fw_a !== exp_fw[0]) begin
            n_fail++;
            $display("FAIL mid_after_count got=%0d exp=%0d", fw_a, exp_fw[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            bit          w;
            logic [4:0]  col;
            logic [4:0]  frame;
            logic [31:0] data;
            bit          clr, match, rng, good;
            int          kmax, s, t, h;
            w     = $urandom_range(0, 1) == 1;
            col   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            frame = 5'($urandom_range(0, 31));
            data  = $urandom;
            clr   = $urandom_range(0, 3) == 0;
            s = ph_s[w]; t = ph_t[w]; h = ph_h[w];
            match = (col == 5'd0);
            rng   = match && (frame >= 5'd20);
            good  = match && !rng;
            if (rng)      exp_err[w] = 1'b1;
            else if (clr) exp_err[w] = 1'b0;
            if (good)     exp_fd[w]  = data;
            send(w, col, frame, data, clr);
            kmax = good ? (s + t + h + 1) : 1;
            for (int k = 1; k <= kmax; k++) begin
                logic [19:0] es;
                logic        eb;
                es = good ? m_strobe(k, frame, s, t) : 20'd0;
                eb = good && m_busy(k, s, t, h);
                n_cmp++;
                if (o_fs(w) !== es || o_busy(w) !== eb || o_ready(w) !== !eb ||
                    o_fd(w) !== exp_fd[w] || o_err(w) !== exp_err[w]) begin
                    n_fail++;
                    $display("FAIL random it=%0d inst=%0d k=%0d got fs=%h busy=%b fd=%h err=%b exp fs=%h busy=%b fd=%h err=%b",
                             it, w, k, o_fs(w), o_busy(w), o_fd(w), o_err(w), es, eb, exp_fd[w], exp_err[w]);
                end
                if (k < kmax) @(negedge clk);
            end
            if (good) exp_fw[w] = exp_fw[w] + 16'd1;
            n_cmp++;
            if (o_fw(w) !== exp_fw[w]) begin
                n_fail++;
                $display("FAIL random_count it=%0d inst=%0d got=%0d exp=%0d", it, w, o_fw(w), exp_fw[w]);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        clk = 1'b0; rst_n = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        req_col = 5'd0; req_frame = 5'd0; req_data = 32'd0;
        for (int w = 0; w < 2; w++) begin
            exp_fd[w] = 32'd0; exp_fw[w] = 16'd0; exp_err[w] = 1'b0;
        end
        ph_s[0] = 1; ph_t[0] = 2; ph_h[0] = 1;
        ph_s[1] = 0; ph_t[1] = 2; ph_h[1] = 0;

        test_reset();
        test_basic();
        test_col_mismatch();
        test_range_err();
        test_back_to_back();
        test_reset_mid_strobe();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
